// File: rtl/fpadd_issue_ctrl.sv
// Issue/collect wrapper around the 5-stage fpadd: operand registers,
// latency token pipe, zero/cancel bypass and an in-order result FIFO.
module fpadd_issue_ctrl #(
  parameter int DEPTH = 8,
  parameter int LAT   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic [31:0]              fp_a,
  output logic [31:0]              fp_b,
  input  logic [31:0]              fp_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_bypass,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_wptr;
  logic [CW-1:0] r_rptr;
  logic [LAT:0]  r_tok;
  logic [LAT:0]  r_bflag;
  logic [31:0]   r_bval [LAT+1];
  logic [32:0]   r_mem  [DEPTH];

  logic        w_acc;
  logic        w_pop;
  logic        w_wr;
  logic        w_full;
  logic        w_za;
  logic        w_zb;
  logic        w_cx;
  logic        w_byp;
  logic [31:0] w_bval;
  logic [32:0] w_wdata;
  logic [32:0] w_head;

  assign in_ready  = (r_occ < DEPTH_C);
  assign w_acc     = in_valid & in_ready;
  assign count     = r_wptr - r_rptr;
  assign out_valid = (count != '0);
  assign w_full    = (count == DEPTH_C);
  assign w_pop     = out_valid & out_ready;
  assign w_wr      = r_tok[LAT];

  assign w_za = (in_a[30:23] == 8'h00);
  assign w_zb = (in_b[30:23] == 8'h00);
  assign w_cx = (in_a[30:0] == in_b[30:0])
              && (in_a[31] != in_b[31]);

  // adder forces the hidden bit, so zero/denormal and x+(-x) skip it
  always_comb begin
    w_byp  = 1'b0;
    w_bval = '0;
    unique case (1'b1)
      (w_za && w_zb): begin
        w_byp  = 1'b1;
        w_bval = {in_a[31] & in_b[31], 31'b0};
      end
      (w_za && !w_zb): begin
        w_byp  = 1'b1;
        w_bval = in_b;
      end
      (!w_za && w_zb): begin
        w_byp  = 1'b1;
        w_bval = in_a;
      end
      (!w_za && !w_zb && w_cx): begin
        w_byp  = 1'b1;
        w_bval = '0;
      end
      default: w_byp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp_a <= '0;
      fp_b <= '0;
    end else if (w_acc) begin
      fp_a <= in_a;
      fp_b <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tok   <= '0;
      r_bflag <= '0;
      for (int i = 0; i <= LAT; i++)
        r_bval[i] <= '0;
    end else begin
      r_tok   <= {r_tok[LAT-1:0], w_acc};
      r_bflag <= {r_bflag[LAT-1:0], w_byp};
      r_bval[0] <= w_bval;
      for (int i = 1; i <= LAT; i++)
        r_bval[i] <= r_bval[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      unique case ({w_acc, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign w_wdata = r_bflag[LAT]
                 ? {1'b1, r_bval[LAT]}
                 : {1'b0, fp_out};

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr[AW-1:0]] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + CW'(1);
      if (w_pop)
        r_rptr <= r_rptr + CW'(1);
    end
  end

  assign w_head     = r_mem[r_rptr[AW-1:0]];
  assign out_data   = out_valid ? w_head[31:0] : '0;
  assign out_bypass = out_valid & w_head[32];

  always_ff @(posedge clk) begin
    if (rst_n)
      a_no_ovf: assert (!(w_wr && w_full && !w_pop));
  end

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Bench for fpadd_issue_ctrl: behavioural 5-stage adder, directed
// vectors, scoreboard queue checked by a separate output monitor.
module tb_fpadd_issue_ctrl;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        y;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        y;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] fp_a;
  logic [31:0] fp_b;
  logic [31:0] fp_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_bypass;
  logic [3:0]  count;

  vec_t vq[$];
  exp_t sb[$];
  int   acc_q[$];
  int   pop_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   n_pop = 0;
  int   max_cnt = 0;
  int   nv_after_rst = 0;

  logic [31:0] ad_s [5] = '{default: 32'h0};

  fpadd_issue_ctrl #(.DEPTH(8), .LAT(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .fp_a       (fp_a),
    .fp_b       (fp_b),
    .fp_out     (fp_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_bypass (out_bypass),
    .count      (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fsum(logic [31:0] a, logic [31:0] b);
    fsum = 32'hDEADBEEF;
    for (int i = 0; i < 11; i++)
      if (vq[i].a == a && vq[i].b == b)
        fsum = vq[i].d;
  endfunction

  // stand-in for fpadd: five registers, never reset
  always @(posedge clk) begin
    ad_s[0] <= fsum(fp_a, fp_b);
    for (int i = 1; i < 5; i++)
      ad_s[i] <= ad_s[i-1];
  end
  assign fp_out = ad_s[4];

  task automatic chk_d(string nm, logic [32:0] act, logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && int'(count) > max_cnt)
      max_cnt = int'(count);
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      n_pop++;
      pop_q.push_back(cyc);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got %h/%b want none",
                 out_data, out_bypass);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.d || out_bypass !== e.y) begin
          n_bad++;
          $display("FAIL result: got %h/%b want %h/%b",
                   out_data, out_bypass, e.d, e.y);
        end
      end
    end
  end

  task automatic add_vec(logic [31:0] a, logic [31:0] b,
                         logic [31:0] d, logic y);
    vq.push_back('{a: a, b: b, d: d, y: y});
  endtask

  task automatic drive(input int base, input int num,
                       input int cycles, output int acc);
    int k = 0;
    int idx;
    for (int c = 0; c < cycles; c++) begin
      idx = base + (k % num);
      in_valid = 1'b1;
      in_a = vq[idx].a;
      in_b = vq[idx].b;
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{d: vq[idx].d, y: vq[idx].y});
        acc_q.push_back(cyc + 1);
        n_acc++;
        k++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    acc = k;
  endtask

  task automatic drain(string nm);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk_i(nm, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int acc;
    int a0;
    int p0;

    add_vec(32'h3F800000, 32'h40000000, 32'h40400000, 1'b0);
    add_vec(32'h40000000, 32'h3F800000, 32'h40400000, 1'b0);
    add_vec(32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0);
    add_vec(32'h40000000, 32'h40000000, 32'h40800000, 1'b0);
    add_vec(32'h40400000, 32'h3F800000, 32'h40800000, 1'b0);
    add_vec(32'h40800000, 32'h40800000, 32'h41000000, 1'b0);
    add_vec(32'h3FC00000, 32'h3FC00000, 32'h40400000, 1'b0);
    add_vec(32'h3F000000, 32'h3F000000, 32'h3F800000, 1'b0);
    add_vec(32'h41000000, 32'h41000000, 32'h41800000, 1'b0);
    add_vec(32'h40A00000, 32'h40A00000, 32'h41200000, 1'b0);
    add_vec(32'h41000000, 32'h3F800000, 32'h41100000, 1'b0);
    add_vec(32'h00000000, 32'h40A00000, 32'h40A00000, 1'b1);
    add_vec(32'h40490FDB, 32'hC0490FDB, 32'h00000000, 1'b1);
    add_vec(32'h80000000, 32'h80000000, 32'h80000000, 1'b1);
    add_vec(32'h00000001, 32'h3F800000, 32'h3F800000, 1'b1);
    add_vec(32'h40400000, 32'h80000000, 32'h40400000, 1'b1);
    add_vec(32'h80000000, 32'h00000000, 32'h00000000, 1'b1);

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_d("rst_fp_a", {1'b0, fp_a}, 33'h0);
    chk_d("rst_fp_b", {1'b0, fp_b}, 33'h0);
    chk_i("rst_count", int'(count), 0);
    chk_i("rst_out_valid", int'(out_valid), 0);
    chk_d("rst_out", {out_bypass, out_data}, 33'h0);
    chk_i("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single add and its latency
    out_ready = 1'b1;
    acc_q.delete();
    pop_q.delete();
    drive(0, 1, 1, acc);
    chk_d("basic_fp_a", {1'b0, fp_a}, {1'b0, 32'h3F800000});
    chk_d("basic_fp_b", {1'b0, fp_b}, {1'b0, 32'h40000000});
    drain("basic_drain");
    chk_i("basic_npop", pop_q.size(), 1);
    if (pop_q.size() == 1 && acc_q.size() == 1)
      chk_i("basic_lat", pop_q[0] - acc_q[0], 6);

    // streaming
    acc_q.delete();
    pop_q.delete();
    drive(0, 8, 8, acc);
    chk_i("stream_acc", acc, 8);
    drain("stream_drain");
    chk_i("stream_npop", pop_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < pop_q.size() && i < acc_q.size())
        chk_i($sformatf("stream_lat%0d", i), pop_q[i] - acc_q[i], 6);

    // bypass cases
    drive(11, 6, 6, acc);
    chk_i("byp_acc", acc, 6);
    drain("byp_drain");

    // backpressure
    out_ready = 1'b0;
    drive(0, 11, 12, acc);
    chk_i("bp_acc", acc, 8);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk_i("bp_in_ready", int'(in_ready), 0);
    chk_i("bp_count", int'(count), 8);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk_i("bp_ready_pre_pop", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk_i("bp_ready_post_pop", int'(in_ready), 1);
    drain("bp_drain");

    // sustained full push/pop
    out_ready = 1'b0;
    drive(0, 11, 8, acc);
    repeat (8) @(posedge clk);
    #1;
    chk_i("full_count", int'(count), 8);
    max_cnt = 0;
    out_ready = 1'b1;
    a0 = n_acc;
    p0 = n_pop;
    drive(0, 11, 30, acc);
    chk_i("full_pops", n_pop - p0, 30);
    chk_i("full_accs", n_acc - a0, 29);
    chk_i("full_max_le8", (max_cnt <= 8) ? 1 : 0, 1);
    drain("full_drain");

    // reset with operations in flight
    drive(0, 3, 3, acc);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_i("mid_rst_count", int'(count), 0);
    chk_i("mid_rst_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nv_after_rst = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) nv_after_rst++;
    end
    chk_i("post_rst_no_out", nv_after_rst, 0);
    chk_i("post_rst_count", int'(count), 0);

    chk_i("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpadd_issue_ctrl.md
Name: fpadd_issue_ctrl

Overview:
- Valid/ready front-end and result collector for the 5-register-stage single-precision adder `fpadd`.
- Registers accepted operand pairs onto the adder's a/b inputs and tracks each operation with a token shift register of fixed latency LAT.
- Captures each result into an in-order output FIFO.
- Handles zero/denormal operands and exact cancellation, which the adder cannot process because it forces the hidden bit to 1, through a bypass path.
- Credit accounting guarantees the FIFO never overflows.

Parameters:
- DEPTH, 8, output FIFO entries; power of two, 2..32.
- LAT, 5, adder clock edges from its a/b input change to a valid out.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- in_a  in  32  IEEE-754 single operand A.
- in_b  in  32  IEEE-754 single operand B.
- fp_a  out  32  registered operand A to `fpadd` a.
- fp_b  out  32  registered operand B to `fpadd` b.
- fp_out  in  32  `fpadd` out.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_data  out  32  result at FIFO head.
- out_bypass  out  1  head result came from the bypass path.
- count  out  $clog2(DEPTH)+1  entries currently stored in the FIFO.

Behaviour:
- Reset (async, rst_n=0) clears:
  - fp_a=0, fp_b=0
  - token/bypass pipeline
  - FIFO pointers, count=0, out_valid=0, out_data=0, out_bypass=0
  - occupancy counter occ=0
- Release is synchronous to clk.
- Accept: in_valid & in_ready at a rising edge.
  - On that edge, fp_a<=in_a and fp_b<=in_b.
  - tok[0]<=1 and bypass info is loaded into side pipeline stage 0.
  - With no accept, fp_a/fp_b hold and tok[0]<=0.
- Token pipeline: tok[LAT:0] shifts by one each edge. Side pipeline (byp flag, byp value) shifts alongside it.
- FIFO write: on the edge where tok[LAT]=1, write value := byp flag ? byp value : fp_out, together with the flag.
  - Accept-to-out_valid latency = LAT+1 = 6 cycles.
  - Back-to-back accepts give one result per cycle.
- Bypass decode on accept (exp = bits 30:23), first match wins:
  - exp_a==0 and exp_b==0 -> value {a[31]&b[31], 31'b0}.
  - exp_a==0 -> value in_b.
  - exp_b==0 -> value in_a.
  - a[30:0]==b[30:0] and a[31]!=b[31] -> value 0x00000000.
  - Otherwise no bypass.
- Inf/NaN is not special-cased and goes through the adder.
- Credit: occ counts in-flight plus stored operations.
  - occ+1 on accept; occ-1 on pop; unchanged when both happen on the same edge.
  - in_ready = (occ < DEPTH), decoded from registers only and never combinationally dependent on in_valid or out_ready.
  - A FIFO write therefore always has space. Writing while full is a design error; a simulation assertion checks it.
- FIFO:
  - Pop = out_valid & out_ready. Empty -> out_valid=0 and out_ready is ignored.
  - out_data/out_bypass show the head entry with no added latency after the write edge. They hold while out_valid & !out_ready.
  - Simultaneous write and pop when full: both occur, count unchanged.
  - Simultaneous write and pop when count=1: the new entry becomes the head, out_valid stays 1.
  - Pointers wrap modulo DEPTH.
- Reset mid-operation: all tokens are discarded. Adder results still draining after reset have no token and are never written. `fpadd` itself is not reset.
- count = write pointer minus read pointer, with the extra MSB distinguishing full from empty.

Test Plan:
- Basic add: in_a=0x3F800000, in_b=0x40000000, single accept -> out_valid rises 6 cycles later with out_data=0x40400000, out_bypass=0.
- Streaming: 8 back-to-back pairs with out_ready=1 -> 8 consecutive results in order starting cycle 6, in_ready stays 1 throughout.
- Bypass: 0x00000000+0x40A00000 -> 0x40A00000 with bypass=1. 0x40490FDB+0xC0490FDB -> 0x00000000 with bypass=1. 0x80000000+0x80000000 -> 0x80000000.
- Backpressure: out_ready=0, in_valid=1 for 12 cycles, DEPTH=8 -> exactly 8 accepts, then in_ready=0, count reaches 8. Raising out_ready drains 8 results in order, and in_ready reasserts the cycle after the first pop.
- Full push/pop: keep occ=DEPTH with out_ready=1 and in_valid=1 continuously -> one accept per pop, count never exceeds 8, no overflow assertion.
- Reset mid-flight: accept 3 ops, assert rst_n=0 two cycles later for one cycle -> count=0, out_valid=0, and no result appears during the following 10 cycles.
